// File: rtl/wb_loader_pkg.sv
// Shared types and constants for the Wishbone SRAM loader.
package wb_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_ACK     = 2'd2
    } state_e;

    localparam int unsigned CTRL_RUN     = 0;
    localparam int unsigned CTRL_CLR     = 1;
    localparam int unsigned STAT_CNT_LSB = 0;
    localparam int unsigned STAT_CNT_W   = 16;
    localparam int unsigned STAT_OWN     = 16;
    localparam logic [31:0] READ_DEFAULT = 32'h0;

    typedef struct packed {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;
    } wb_req_t;

endpackage

// File: rtl/wb_loader_regs.sv
// CTRL/STATUS registers and the saturating count of accepted SRAM writes.
module wb_loader_regs
    import wb_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ctrl_wr,
    input  logic [1:0]  ctrl_wdata,
    input  logic        cnt_inc,
    output logic        run,
    output logic [31:0] ctrl_rdata_c,
    output logic [31:0] status_rdata_c
);

    localparam int unsigned CNT_W = STAT_CNT_W;

    logic             run_d;
    logic [CNT_W-1:0] wcount;
    logic [CNT_W-1:0] wcount_d;

    // Clear wins over an increment landing in the same cycle.
    always_comb begin
        run_d    = run;
        wcount_d = wcount;
        if (ctrl_wr) begin
            run_d = ctrl_wdata[CTRL_RUN];
        end
        if (ctrl_wr && ctrl_wdata[CTRL_CLR]) begin
            wcount_d = '0;
        end else if (cnt_inc && (wcount != {CNT_W{1'b1}})) begin
            wcount_d = wcount + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run    <= 1'b0;
            wcount <= '0;
        end else begin
            run    <= run_d;
            wcount <= wcount_d;
        end
    end

    always_comb begin
        ctrl_rdata_c           = READ_DEFAULT;
        ctrl_rdata_c[CTRL_RUN] = run;
        status_rdata_c         = READ_DEFAULT;
        status_rdata_c[STAT_CNT_LSB +: STAT_CNT_W] = wcount;
        status_rdata_c[STAT_OWN] = ~run;
    end

endmodule

// File: rtl/wb_sram_loader.sv
// Wishbone slave that loads/reads the core program SRAM while holding the core in reset.
module wb_sram_loader
    import wb_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADR = 32'h3000_0000,
    parameter int unsigned AW       = 10,
    parameter logic [15:0] CTRL_OFF = 16'h8000
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_n,
    input  logic          wbs_cyc_i,
    input  logic          wbs_stb_i,
    input  logic          wbs_we_i,
    input  logic [3:0]    wbs_sel_i,
    input  logic [31:0]   wbs_adr_i,
    input  logic [31:0]   wbs_dat_i,
    output logic          wbs_ack_o,
    output logic [31:0]   wbs_dat_o,
    output logic          sram_en_o,
    output logic [3:0]    sram_we_o,
    output logic [AW-1:0] sram_addr_o,
    output logic [31:0]   sram_wdata_o,
    input  logic [31:0]   sram_rdata_i,
    output logic          core_rst_n_o,
    output logic          sram_own_o
);

    localparam logic [16:0] WIN_BYTES = 17'(4 << AW);
    localparam logic [13:0] CTRL_WORD = CTRL_OFF[15:2];
    localparam logic [13:0] STAT_WORD = CTRL_WORD + 14'd1;

    wb_req_t     bus;
    state_e      state;
    state_e      state_d;
    logic        ack_d;
    logic [31:0] dat_d;
    logic        req;
    logic        in_win;
    logic        is_ctrl;
    logic        is_stat;
    logic        run;
    logic        own;
    logic        ctrl_wr;
    logic        cnt_inc;
    logic [31:0] ctrl_rdata;
    logic [31:0] status_rdata;
    logic        adr_lsb_unused;

    assign bus = '{we: wbs_we_i, sel: wbs_sel_i, adr: wbs_adr_i, dat: wbs_dat_i};
    assign adr_lsb_unused = ^bus.adr[1:0];

    assign req     = wbs_cyc_i & wbs_stb_i & (bus.adr[31:16] == BASE_ADR[31:16]);
    assign in_win  = {1'b0, bus.adr[15:0]} < WIN_BYTES;
    assign is_ctrl = bus.adr[15:2] == CTRL_WORD;
    assign is_stat = bus.adr[15:2] == STAT_WORD;

    assign own          = ~run;
    assign core_rst_n_o = run;
    assign sram_own_o   = own;

    wb_loader_regs u_regs (
        .clk            (wb_clk_i),
        .rst_n          (wb_rst_n),
        .ctrl_wr        (ctrl_wr),
        .ctrl_wdata     (bus.dat[1:0]),
        .cnt_inc        (cnt_inc),
        .run            (run),
        .ctrl_rdata_c   (ctrl_rdata),
        .status_rdata_c (status_rdata)
    );

    // SRAM strobe launches in the request cycle so read data is back one cycle later.
    always_comb begin
        state_d      = state;
        ack_d        = 1'b0;
        dat_d        = READ_DEFAULT;
        ctrl_wr      = 1'b0;
        cnt_inc      = 1'b0;
        sram_en_o    = 1'b0;
        sram_we_o    = 4'h0;
        sram_addr_o  = '0;
        sram_wdata_o = 32'h0;
        unique case (state)
            ST_IDLE: begin
                if (req && wb_rst_n) begin
                    if (in_win) begin
                        if (own) begin
                            sram_en_o    = 1'b1;
                            sram_addr_o  = bus.adr[AW+1:2];
                            sram_we_o    = bus.we ? bus.sel : 4'h0;
                            sram_wdata_o = bus.we ? bus.dat : 32'h0;
                        end
                        cnt_inc = bus.we & own & (|bus.sel);
                        if (bus.we || !own) begin
                            state_d = ST_ACK;
                            ack_d   = 1'b1;
                        end else begin
                            state_d = ST_RD_WAIT;
                        end
                    end else begin
                        state_d = ST_ACK;
                        ack_d   = 1'b1;
                        ctrl_wr = bus.we & is_ctrl;
                        if (!bus.we) begin
                            dat_d = is_ctrl ? ctrl_rdata :
                                    (is_stat ? status_rdata : READ_DEFAULT);
                        end
                    end
                end
            end
            ST_RD_WAIT: begin
                state_d = ST_ACK;
                ack_d   = 1'b1;
                dat_d   = sram_rdata_i;
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state     <= ST_IDLE;
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= READ_DEFAULT;
        end else begin
            state     <= state_d;
            wbs_ack_o <= ack_d;
            wbs_dat_o <= dat_d;
        end
    end

endmodule

// File: tb/tb_wb_sram_loader.sv
// Randomised bench for wb_sram_loader against a transaction-level model.
module tb_wb_sram_loader;

    localparam int unsigned AW    = 10;
    localparam int unsigned WORDS = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cyc, stb, we;
    logic [3:0]    sel;
    logic [31:0]   adr, dat;
    logic          ack;
    logic [31:0]   rdat;
    logic          sram_en;
    logic [3:0]    sram_we;
    logic [AW-1:0] sram_addr;
    logic [31:0]   sram_wdata;
    logic [31:0]   sram_rdata;
    logic          core_rst_n, sram_own;

    always #5 clk = ~clk;

    wb_sram_loader dut (
        .wb_clk_i     (clk),
        .wb_rst_n     (rst_n),
        .wbs_cyc_i    (cyc),
        .wbs_stb_i    (stb),
        .wbs_we_i     (we),
        .wbs_sel_i    (sel),
        .wbs_adr_i    (adr),
        .wbs_dat_i    (dat),
        .wbs_ack_o    (ack),
        .wbs_dat_o    (rdat),
        .sram_en_o    (sram_en),
        .sram_we_o    (sram_we),
        .sram_addr_o  (sram_addr),
        .sram_wdata_o (sram_wdata),
        .sram_rdata_i (sram_rdata),
        .core_rst_n_o (core_rst_n),
        .sram_own_o   (sram_own)
    );

    // SRAM behaviour: read-before-write, one cycle latency
    logic [31:0] sram_mem [WORDS];
    always @(posedge clk) begin
        if (sram_en) begin
            sram_rdata <= sram_mem[sram_addr];
            for (int b = 0; b < 4; b++)
                if (sram_we[b]) sram_mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
        end
    end

    // Reference model state
    logic [31:0] m_mem [WORDS];
    logic        m_run;
    logic [15:0] m_wcount;

    // Expected outputs for the current cycle
    logic          e_ack, e_en;
    logic [31:0]   e_dat, e_wdata;
    logic [3:0]    e_we;
    logic [AW-1:0] e_addr;
    logic          chk_on = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("ack", 32'(ack), 32'(e_ack));
            check("dat", rdat, e_dat);
            check("sram_en", 32'(sram_en), 32'(e_en));
            check("sram_we", 32'(sram_we), 32'(e_we));
            check("sram_addr", 32'(sram_addr), 32'(e_addr));
            if (e_we != 4'h0) check("sram_wdata", sram_wdata, e_wdata);
            check("core_rst_n", 32'(core_rst_n), 32'(m_run));
            check("own", 32'(sram_own), 32'(!m_run));
        end
    end

    function automatic logic [31:0] model_read(input logic [31:0] a);
        logic [15:0] off = a[15:0];
        if (off < 16'h1000) return m_run ? 32'h0 : m_mem[a[AW+1:2]];
        if (off[15:2] == 14'h2000) return {31'h0, m_run};
        if (off[15:2] == 14'h2001) return {15'h0, !m_run, m_wcount};
        return 32'h0;
    endfunction

    task automatic model_commit(input logic w, input logic [31:0] a, input logic [31:0] d,
                                input logic [3:0] s);
        logic [15:0] off = a[15:0];
        if (!w) return;
        if (off < 16'h1000) begin
            if (!m_run) begin
                for (int b = 0; b < 4; b++)
                    if (s[b]) m_mem[a[AW+1:2]][8*b +: 8] = d[8*b +: 8];
                if (s != 4'h0 && m_wcount != 16'hFFFF) m_wcount = m_wcount + 16'd1;
            end
        end else if (off[15:2] == 14'h2000) begin
            m_run = d[0];
            if (d[1]) m_wcount = 16'h0;
        end
    endtask

    task automatic drop();
        cyc = 1'b0; stb = 1'b0;
        e_ack = 1'b0; e_dat = 32'h0; e_en = 1'b0; e_we = 4'h0; e_addr = '0; e_wdata = 32'h0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            drop();
            cyc = ($urandom_range(0, 3) == 0);
            we  = 1'($urandom);
            sel = 4'($urandom);
            adr = 32'h3000_0000 | 32'($urandom_range(0, 16'hFFFF));
            dat = $urandom;
            @(posedge clk); #1;
        end
    endtask

    // One Wishbone access; master holds the request until it sees ack
    task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, output logic [31:0] rd);
        logic        hit, win, own, strobe;
        logic [31:0] exp_rd;
        hit    = a[31:16] == 16'h3000;
        win    = a[15:0] < 16'h1000;
        own    = !m_run;
        strobe = hit && win && own;
        exp_rd = model_read(a);
        rd     = 32'h0;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d; sel = s;
        e_ack = 1'b0; e_dat = 32'h0;
        e_en    = strobe;
        e_we    = (strobe && w) ? s : 4'h0;
        e_addr  = strobe ? a[AW+1:2] : '0;
        e_wdata = d;
        if (!hit) begin
            repeat (10) begin @(posedge clk); #1; end
            drop();
            return;
        end
        @(posedge clk); #1;
        model_commit(w, a, d, s);
        e_en = 1'b0; e_we = 4'h0; e_addr = '0;
        if (win && !w && own) begin @(posedge clk); #1; end
        e_ack = 1'b1;
        e_dat = w ? 32'h0 : exp_rd;
        @(negedge clk);
        rd = rdat;
        @(posedge clk); #1;
        drop();
    endtask

    logic [31:0] rd;
    logic [15:0] off;

    initial begin
        for (int i = 0; i < int'(WORDS); i++) begin
            sram_mem[i] = $urandom;
            m_mem[i]    = sram_mem[i];
        end
        m_run = 1'b0; m_wcount = 16'h0;
        we = 1'b0; sel = 4'h0; adr = 32'h0; dat = 32'h0;
        drop();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        chk_on = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle_cycles(2);

        // Reset while a read is in flight
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3000_0040; sel = 4'hF;
        e_en = 1'b1; e_addr = 10'd16;
        @(posedge clk); #1;
        drop();
        rst_n = 1'b0;
        m_run = 1'b0; m_wcount = 16'h0;
        #1;
        check("rst_ack", 32'(ack), 32'h0);
        check("rst_dat", rdat, 32'h0);
        check("rst_own", 32'(sram_own), 32'h1);
        check("rst_core", 32'(core_rst_n), 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle_cycles(1);

        // Full-word write and read back
        txn(1'b1, 32'h3000_0010, 32'hDEAD_BEEF, 4'hF, rd);
        txn(1'b0, 32'h3000_0010, 32'h0, 4'hF, rd);
        check("readback", rd, 32'hDEAD_BEEF);
        txn(1'b0, 32'h3000_8004, 32'h0, 4'hF, rd);
        check("status1", rd, 32'h0001_0001);

        // Byte write, then a write with no byte lanes
        txn(1'b1, 32'h3000_0020, 32'h1122_3344, 4'b0010, rd);
        txn(1'b1, 32'h3000_0024, 32'h5566_7788, 4'b0000, rd);
        txn(1'b0, 32'h3000_8004, 32'h0, 4'hF, rd);
        check("status2", rd, 32'h0001_0002);
        txn(1'b0, 32'h3000_0020, 32'h0, 4'hF, rd);

        // Core running: SRAM window goes dark
        txn(1'b1, 32'h3000_8000, 32'h1, 4'hF, rd);
        check("core_run", 32'(core_rst_n), 32'h1);
        txn(1'b1, 32'h3000_0100, 32'hCAFE_F00D, 4'hF, rd);
        txn(1'b0, 32'h3000_0100, 32'h0, 4'hF, rd);
        check("dark_read", rd, 32'h0);
        txn(1'b0, 32'h3000_8000, 32'h0, 4'hF, rd);
        check("ctrl_run", rd, 32'h1);
        txn(1'b1, 32'h3000_8000, 32'h0, 4'hF, rd);
        check("own_back", 32'(sram_own), 32'h1);
        txn(1'b0, 32'h3000_0100, 32'h0, 4'hF, rd);

        // Outside the block and unmapped inside it
        txn(1'b0, 32'h3100_0000, 32'h0, 4'hF, rd);
        txn(1'b0, 32'h3000_9000, 32'h0, 4'hF, rd);
        check("unmapped", rd, 32'h0);
        txn(1'b1, 32'h3000_9000, 32'h1234_5678, 4'hF, rd);

        // Saturation of the write counter, then clear
        force dut.u_regs.wcount = 16'hFFFE;
        @(posedge clk); #1;
        release dut.u_regs.wcount;
        m_wcount = 16'hFFFE;
        for (int i = 0; i < 3; i++) txn(1'b1, 32'h3000_0200 + 32'(4 * i), $urandom, 4'hF, rd);
        txn(1'b0, 32'h3000_8004, 32'h0, 4'hF, rd);
        check("sat", rd, 32'h0001_FFFF);
        txn(1'b1, 32'h3000_8000, 32'h2, 4'hF, rd);
        txn(1'b1, 32'h3000_0300, 32'hA5A5_A5A5, 4'hF, rd);
        txn(1'b0, 32'h3000_8004, 32'h0, 4'hF, rd);
        check("cleared", rd, 32'h0001_0001);
        txn(1'b0, 32'h3000_8000, 32'h0, 4'hF, rd);
        check("ctrl_clr", rd, 32'h0);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            int unsigned k = $urandom_range(0, 99);
            if (k < 60) begin
                txn(1'($urandom), 32'h3000_0000 | 32'($urandom_range(0, 16'h0FFF)),
                    $urandom, 4'($urandom), rd);
            end else if (k < 72) begin
                txn(1'b1, 32'h3000_8000, {30'($urandom), 1'($urandom_range(0, 3) == 0),
                    1'($urandom)}, 4'hF, rd);
            end else if (k < 85) begin
                txn(1'b0, 32'h3000_8000 | 32'($urandom_range(0, 1) * 4), 32'h0, 4'hF, rd);
            end else if (k < 95) begin
                off = 16'($urandom_range(16'h1000, 16'hFFFF));
                if (off[15:3] == 13'h1000) off = 16'h9000;
                txn(1'($urandom), {16'h3000, off}, $urandom, 4'hF, rd);
            end else begin
                txn(1'($urandom), {16'($urandom_range(16'h3001, 16'hFFFF)), 16'($urandom)},
                    $urandom, 4'hF, rd);
            end
            idle_cycles(int'($urandom_range(0, 2)));
        end

        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
